// File: rtl/rs_ff_bank_if.sv
// Data, scan and mode-configuration signals of the configurable register bank.
// The interface WIDTH must match the WIDTH of the rs_ff_bank it connects to.
interface rs_ff_bank_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] D;
   logic [WIDTH-1:0] E;
   logic [WIDTH-1:0] Q;
   logic             SE;
   logic             SI;
   logic             SO;
   logic             SCAN_MODE;
   logic             cfg_start;
   logic             cfg_valid;
   logic             cfg_si;
   logic             cfg_busy;
   logic             cfg_done;

   modport slave (
      input  D, E, SE, SI, SCAN_MODE, cfg_start, cfg_valid, cfg_si,
      output Q, SO, cfg_busy, cfg_done
   );

   modport master (
      output D, E, SE, SI, SCAN_MODE, cfg_start, cfg_valid, cfg_si,
      input  Q, SO, cfg_busy, cfg_done
   );
endinterface

// File: rtl/rs_ff_bank.sv
// WIDTH configurable flops with per-bit enable, scan chain and a serially
// loaded per-bit output mode (registered or enable-gated bypass).
module rs_ff_cell #(
   parameter logic RST_BIT = 1'b0
) (
   input  logic CK,
   input  logic RS,
   input  logic d,
   input  logic e,
   input  logic se,
   input  logic si,
   input  logic mode_eff,
   output logic ff_q,
   output logic q
);
   logic ff_d;

   always_comb begin
      ff_d = ff_q;
      if (se)     ff_d = si;
      else if (e) ff_d = d;
   end

   always_ff @(posedge CK) begin
      if (!RS) ff_q <= RST_BIT;
      else     ff_q <= ff_d;
   end

   // Bypass follows D while enabled and falls back to the stored bit otherwise.
   assign q = (mode_eff && e) ? d : ff_q;
endmodule

module rs_ff_bank #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic         CK,
   input  logic         RS,
   rs_ff_bank_if.slave  bus
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] mode_q, mode_d;
   logic [CW-1:0]    cnt_q;
   logic             busy_q, done_q;
   logic [WIDTH-1:0] ff_q, scan_src, mode_eff;

   // First bit shifted in ends up at mode[0] after WIDTH shifts.
   always_comb begin
      mode_d            = mode_q >> 1;
      mode_d[WIDTH-1]   = bus.cfg_si;
   end

   always_ff @(posedge CK) begin
      if (!RS) begin
         state_q <= IDLE;
         mode_q  <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (bus.cfg_start) begin
               state_q <= LOAD;
               cnt_q   <= '0;
               busy_q  <= 1'b1;
            end
            LOAD: if (bus.cfg_valid) begin
               mode_q <= mode_d;
               if (cnt_q == LAST) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DONE: if (bus.cfg_start) begin
               state_q <= LOAD;
               cnt_q   <= '0;
               busy_q  <= 1'b1;
               done_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Mode only applies once a full load has landed and test mode is off.
   assign mode_eff = mode_q & {WIDTH{done_q & ~bus.SCAN_MODE}};

   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      if (g == 0) begin : g_head
         assign scan_src[g] = bus.SI;
      end else begin : g_chain
         assign scan_src[g] = ff_q[g-1];
      end
      rs_ff_cell #(.RST_BIT(RST_VAL[g])) u_cell (
         .CK       (CK),
         .RS       (RS),
         .d        (bus.D[g]),
         .e        (bus.E[g]),
         .se       (bus.SE),
         .si       (scan_src[g]),
         .mode_eff (mode_eff[g]),
         .ff_q     (ff_q[g]),
         .q        (bus.Q[g])
      );
   end

   assign bus.SO       = ff_q[WIDTH-1];
   assign bus.cfg_busy = busy_q;
   assign bus.cfg_done = done_q;
endmodule

// File: tb/tb_rs_ff_bank.sv
// Directed checks of rs_ff_bank: reset, enable load, scan, mode load/bypass,
// scan-mode override, mid-load reset, and a WIDTH=1 build.
module tb_rs_ff_bank;
   logic CK = 1'b0;
   logic RS;
   int   errors = 0;
   int   checks = 0;

   rs_ff_bank_if #(.WIDTH(8)) bus ();
   rs_ff_bank_if #(.WIDTH(1)) bus1 ();

   rs_ff_bank #(.WIDTH(8), .RST_VAL(8'hA5)) dut (.CK(CK), .RS(RS), .bus(bus));
   rs_ff_bank #(.WIDTH(1), .RST_VAL(1'b1))  dut1 (.CK(CK), .RS(RS), .bus(bus1));

   always #5 CK = ~CK;

   task automatic step();
      @(posedge CK);
      #1;
   endtask

   task automatic test_reset();
      RS = 1'b0;
      step(); step();
      checks++; if (bus.Q !== 8'hA5) begin errors++; $display("FAIL rst_q got %h exp a5", bus.Q); end
      checks++; if (bus.SO !== 1'b1) begin errors++; $display("FAIL rst_so got %b exp 1", bus.SO); end
      checks++; if (bus.cfg_done !== 1'b0 || bus.cfg_busy !== 1'b0) begin
         errors++; $display("FAIL rst_cfg got busy=%b done=%b exp 0 0", bus.cfg_busy, bus.cfg_done); end
      // overwrite, then reset with scan and enable active
      RS = 1'b1; bus.E = 8'hFF; bus.D = 8'h00;
      step();
      checks++; if (bus.Q !== 8'h00) begin errors++; $display("FAIL pre_rst_load got %h exp 00", bus.Q); end
      RS = 1'b0; bus.SE = 1'b1; bus.SI = 1'b0; bus.cfg_start = 1'b1;
      step();
      checks++; if (bus.Q !== 8'hA5) begin errors++; $display("FAIL rst_wins got %h exp a5", bus.Q); end
      checks++; if (bus.cfg_busy !== 1'b0) begin errors++; $display("FAIL rst_start got busy=%b exp 0", bus.cfg_busy); end
      RS = 1'b1; bus.SE = 1'b0; bus.E = 8'h00; bus.cfg_start = 1'b0;
   endtask

   task automatic test_functional();
      bus.D = 8'h3C; bus.E = 8'h0F;
      step();
      checks++; if (bus.Q !== 8'hAC) begin errors++; $display("FAIL func_load got %h exp ac", bus.Q); end
      bus.D = 8'h55; bus.E = 8'hFF; #1;
      checks++; if (bus.Q !== 8'hAC) begin errors++; $display("FAIL func_no_bypass got %h exp ac", bus.Q); end
      step();
      checks++; if (bus.Q !== 8'h55) begin errors++; $display("FAIL func_full got %h exp 55", bus.Q); end
      bus.E = 8'h00; bus.D = 8'hFF;
      step();
      checks++; if (bus.Q !== 8'h55) begin errors++; $display("FAIL func_hold got %h exp 55", bus.Q); end
   endtask

   task automatic test_scan();
      logic [7:0] si_seq = 8'b1011_0010; // MSB is the first bit shifted
      logic [7:0] prior  = 8'h55;
      bus.SE = 1'b1; bus.E = 8'hFF; bus.D = 8'h00;
      for (int k = 0; k < 8; k++) begin
         bus.SI = si_seq[7-k];
         #1;
         checks++; if (bus.SO !== prior[7-k]) begin
            errors++; $display("FAIL scan_so[%0d] got %b exp %b", k, bus.SO, prior[7-k]); end
         step();
      end
      checks++; if (bus.Q !== 8'hB2) begin errors++; $display("FAIL scan_q got %h exp b2", bus.Q); end
      bus.SE = 1'b0; bus.E = 8'h00;
   endtask

   task automatic test_config();
      logic [7:0] bits = 8'b1000_0001; // bits[k] is the k-th bit sent
      bus.cfg_start = 1'b1;
      step();
      bus.cfg_start = 1'b0;
      checks++; if (bus.cfg_busy !== 1'b1 || bus.cfg_done !== 1'b0) begin
         errors++; $display("FAIL cfg_begin got busy=%b done=%b exp 1 0", bus.cfg_busy, bus.cfg_done); end
      for (int k = 0; k < 8; k++) begin
         if (k == 3 || k == 5) begin
            // idle cycle; a stray start must not restart the count
            bus.cfg_valid = 1'b0; bus.cfg_start = (k == 3);
            step();
            bus.cfg_start = 1'b0;
         end
         bus.cfg_valid = 1'b1; bus.cfg_si = bits[k];
         if (k == 7) begin
            bus.cfg_start = 1'b1;
            #1;
            checks++; if (bus.cfg_busy !== 1'b1 || bus.cfg_done !== 1'b0) begin
               errors++; $display("FAIL cfg_pre_last got busy=%b done=%b exp 1 0", bus.cfg_busy, bus.cfg_done); end
         end
         step();
      end
      bus.cfg_valid = 1'b0; bus.cfg_start = 1'b0;
      checks++; if (bus.cfg_busy !== 1'b0 || bus.cfg_done !== 1'b1) begin
         errors++; $display("FAIL cfg_done got busy=%b done=%b exp 0 1", bus.cfg_busy, bus.cfg_done); end
      step();
      checks++; if (bus.cfg_done !== 1'b1 || bus.cfg_busy !== 1'b0) begin
         errors++; $display("FAIL cfg_start_dropped got busy=%b done=%b exp 0 1", bus.cfg_busy, bus.cfg_done); end
      bus.D = 8'hFF; bus.E = 8'h81; #1;
      checks++; if (bus.Q !== 8'hB3) begin errors++; $display("FAIL bypass_ff got %h exp b3", bus.Q); end
      bus.D = 8'h00; #1;
      checks++; if (bus.Q !== 8'h32) begin errors++; $display("FAIL bypass_00 got %h exp 32", bus.Q); end
      bus.E = 8'h00; #1;
      checks++; if (bus.Q !== 8'hB2) begin errors++; $display("FAIL bypass_hold got %h exp b2", bus.Q); end
   endtask

   task automatic test_scan_mode();
      bus.E = 8'h81; bus.D = 8'h00; bus.SCAN_MODE = 1'b1; #1;
      checks++; if (bus.Q !== 8'hB2) begin errors++; $display("FAIL scanmode_q got %h exp b2", bus.Q); end
      bus.SCAN_MODE = 1'b0; #1;
      checks++; if (bus.Q !== 8'h32) begin errors++; $display("FAIL scanmode_off got %h exp 32", bus.Q); end
      bus.E = 8'h00; bus.cfg_start = 1'b1;
      step();
      bus.cfg_start = 1'b0; bus.E = 8'h81; #1;
      checks++; if (bus.cfg_done !== 1'b0 || bus.cfg_busy !== 1'b1) begin
         errors++; $display("FAIL reload_flags got busy=%b done=%b exp 1 0", bus.cfg_busy, bus.cfg_done); end
      checks++; if (bus.Q !== 8'hB2) begin errors++; $display("FAIL reload_reg got %h exp b2", bus.Q); end
      // new mode 8'hFF loaded entirely under SCAN_MODE
      bus.E = 8'h00; bus.SCAN_MODE = 1'b1; bus.cfg_valid = 1'b1; bus.cfg_si = 1'b1;
      for (int k = 0; k < 8; k++) step();
      bus.cfg_valid = 1'b0;
      checks++; if (bus.cfg_done !== 1'b1) begin errors++; $display("FAIL scanmode_load got done=%b exp 1", bus.cfg_done); end
      bus.E = 8'h0F; #1;
      checks++; if (bus.Q !== 8'hB2) begin errors++; $display("FAIL scanmode_forced got %h exp b2", bus.Q); end
      bus.SCAN_MODE = 1'b0; #1;
      checks++; if (bus.Q !== 8'hB0) begin errors++; $display("FAIL mode_ff got %h exp b0", bus.Q); end
      bus.E = 8'h00;
   endtask

   task automatic test_reset_mid_load();
      bus.cfg_start = 1'b1;
      step();
      bus.cfg_start = 1'b0; bus.cfg_valid = 1'b1; bus.cfg_si = 1'b1;
      for (int k = 0; k < 4; k++) step();
      RS = 1'b0;
      step();
      RS = 1'b1;
      checks++; if (bus.cfg_busy !== 1'b0 || bus.cfg_done !== 1'b0) begin
         errors++; $display("FAIL midrst_flags got busy=%b done=%b exp 0 0", bus.cfg_busy, bus.cfg_done); end
      checks++; if (bus.Q !== 8'hA5) begin errors++; $display("FAIL midrst_q got %h exp a5", bus.Q); end
      for (int k = 0; k < 8; k++) step();
      bus.cfg_valid = 1'b0;
      checks++; if (bus.cfg_busy !== 1'b0 || bus.cfg_done !== 1'b0) begin
         errors++; $display("FAIL midrst_idle got busy=%b done=%b exp 0 0", bus.cfg_busy, bus.cfg_done); end
      // a later bypass attempt shows mode stayed cleared (registered path)
      bus.E = 8'hFF; bus.D = 8'h00; #1;
      checks++; if (bus.Q !== 8'hA5) begin errors++; $display("FAIL midrst_mode got %h exp a5", bus.Q); end
      bus.E = 8'h00;
   endtask

   task automatic test_width1();
      bus1.cfg_start = 1'b1;
      step();
      bus1.cfg_start = 1'b0;
      checks++; if (bus1.cfg_busy !== 1'b1) begin errors++; $display("FAIL w1_busy got %b exp 1", bus1.cfg_busy); end
      bus1.cfg_valid = 1'b1; bus1.cfg_si = 1'b1;
      step();
      bus1.cfg_valid = 1'b0;
      checks++; if (bus1.cfg_done !== 1'b1 || bus1.cfg_busy !== 1'b0) begin
         errors++; $display("FAIL w1_done got busy=%b done=%b exp 0 1", bus1.cfg_busy, bus1.cfg_done); end
      bus1.E = 1'b1; bus1.D = 1'b0; #1;
      checks++; if (bus1.Q !== 1'b0 || bus1.SO !== 1'b1) begin
         errors++; $display("FAIL w1_bypass got q=%b so=%b exp 0 1", bus1.Q, bus1.SO); end
      bus1.E = 1'b0; bus1.SE = 1'b1; bus1.SI = 1'b0;
      step();
      bus1.SE = 1'b0;
      checks++; if (bus1.SO !== 1'b0) begin errors++; $display("FAIL w1_scan got %b exp 0", bus1.SO); end
   endtask

   initial begin
      RS = 1'b0;
      bus.D = '0; bus.E = '0; bus.SE = 1'b0; bus.SI = 1'b0; bus.SCAN_MODE = 1'b0;
      bus.cfg_start = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_si = 1'b0;
      bus1.D = '0; bus1.E = '0; bus1.SE = 1'b0; bus1.SI = 1'b0; bus1.SCAN_MODE = 1'b0;
      bus1.cfg_start = 1'b0; bus1.cfg_valid = 1'b0; bus1.cfg_si = 1'b0;
      test_reset();
      test_functional();
      test_scan();
      test_config();
      test_scan_mode();
      test_reset_mid_load();
      test_width1();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
